fix22_to_fp32: RTL and testbench
================================

FIX22_TO_FP32 -- requirements
Module: fix22_to_fp32

Interface
REQ-001 Parameter: FIX_W, 22, input fixed-point word width in bits, two's complement.
REQ-002 Parameter: FRAC_W, 20, fractional bits of input (Q1.20 format plus sign), matching the CORDIC fixed-point outputs.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: data_in  input  FIX_W  signed fixed-point value, value = data_in * 2^-FRAC_W.
REQ-006 Port: in_valid  input  1  data_in valid.
REQ-007 Port: in_ready  output  1  converter can accept a word.
REQ-008 Port: result  output  32  IEEE-754 single-precision encoding of the accepted word.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.

Function
REQ-011 The FSM SHALL have states IDLE, NORM, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge with in_valid=1 and in_ready=1.
REQ-013 On transfer, the block SHALL register sign = data_in[FIX_W-1], mag = |data_in| (FIX_W bits, unsigned), shift count = 0, and enter NORM.
REQ-014 In NORM, each cycle: if mag==0 or mag[FIX_W-1]==1, enter DONE; otherwise shift mag left 1 and increment count.
REQ-015 On entry to DONE, result SHALL be registered as follows: sign bit = sign; exponent = 127 + (FIX_W-1-FRAC_W) - count; mantissa = mag[FIX_W-2:0] left-aligned in 23 bits, zero-filled.
REQ-016 If mag==0, result SHALL be 32'h00000000 (positive zero), regardless of sign.
REQ-017 The conversion SHALL be exact, with no rounding. All 22-bit magnitudes, including 2^21 from -2^21, SHALL fit in the 24-bit significand.
REQ-018 out_valid SHALL be 1 exactly in DONE.
REQ-019 result SHALL be held stable while out_valid=1 and out_ready=0.
REQ-020 In DONE with out_ready=1, the FSM SHALL return to IDLE. in_ready SHALL rise the following cycle, with no same-cycle accept.
REQ-021 Latency: for an accept at edge k and a leading-one position p, out_valid SHALL be 1 after edge k+1+(FIX_W-1-p). For zero input, out_valid SHALL be 1 after edge k+1. Maximum latency is 22 cycles.
REQ-022 data_in and in_valid SHALL be ignored outside IDLE.

Reset
REQ-023 When reset=1 at a rising edge, the block SHALL set: state IDLE, in_ready=1, out_valid=0, result=32'h0, mag=0, count=0, sign=0.
REQ-024 Reset asserted in NORM or DONE SHALL abort the conversion with no output pulse. Reset SHALL take precedence over a simultaneous in_valid or out_ready.

Structure
REQ-025 Shared package fp_conv_pkg SHALL hold FP32_BIAS=127, FP32_MANT_W=23, FP32_EXP_W=8, and the state enum typedef (IDLE, NORM, DONE).
REQ-026 The design SHALL be a single module with no sub-module; normalization is iterative (one bit per cycle).
REQ-027 count SHALL be 5 bits wide, with a maximum value of 21.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- data_in=22'h100000 (1.0) -> result=32'h3F800000, out_valid after edge k+2.
- data_in=22'h200000 (-2.0) -> result=32'hC0000000, out_valid after edge k+1.
- data_in=22'h000001 (2^-20) -> result=32'h35800000, out_valid after edge k+22.
- data_in=22'h000000 -> result=32'h00000000 after edge k+1. Also data_in=22'h380000 (-0.5) -> result=32'hBF000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 -> IDLE next cycle.
- Reset pulse mid-NORM on 22'h000001 -> next cycle state IDLE, out_valid=0, result=0. The next word, 22'h080000, then yields 32'h3F000000.

Source files
------------

// File: rtl/fp_conv_pkg.sv
// Shared constants and FSM state type for the fixed-point to FP32 converter.
package fp_conv_pkg;

    localparam int unsigned FP32_BIAS   = 127;
    localparam int unsigned FP32_MANT_W = 23;
    localparam int unsigned FP32_EXP_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } conv_state_e;

endpackage : fp_conv_pkg

// File: rtl/fix22_to_fp32.sv
// Exact signed fixed-point (Q1.20 + sign) to IEEE-754 single conversion.
// Normalises iteratively, one left shift per cycle, with a valid/ready handshake on both sides.
module fix22_to_fp32
    import fp_conv_pkg::*;
#(
    parameter int unsigned FIX_W  = 22,
    parameter int unsigned FRAC_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FIX_W-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      result,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W     = 5;
    localparam int unsigned EXP_BASE  = FP32_BIAS + (FIX_W - 1 - FRAC_W);
    localparam int unsigned MANT_PAD  = FP32_MANT_W - (FIX_W - 1);

    conv_state_e            state_q, state_d;
    logic                   sign_q, sign_d;
    logic [FIX_W-1:0]       mag_q, mag_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [31:0]            result_q, result_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic                   norm_done;
    logic [FP32_EXP_W-1:0]  exp_field;
    logic [FP32_MANT_W-1:0] mant_field;

    // Normalisation ends on a zero magnitude or once the leading one reaches the MSB.
    assign norm_done  = (mag_q == '0) || mag_q[FIX_W-1];
    assign exp_field  = FP32_EXP_W'(EXP_BASE) - FP32_EXP_W'(count_q);
    assign mant_field = FP32_MANT_W'(mag_q[FIX_W-2:0]) << MANT_PAD;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = NORM;
            NORM:    if (norm_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        sign_d      = sign_q;
        mag_d       = mag_q;
        count_d     = count_q;
        result_d    = result_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = data_in[FIX_W-1];
                    mag_d   = data_in[FIX_W-1] ? (~data_in + FIX_W'(1)) : data_in;
                    count_d = '0;
                end
            end
            NORM: begin
                if (norm_done) begin
                    result_d = (mag_q == '0) ? 32'h0 : {sign_q, exp_field, mant_field};
                end else begin
                    mag_d   = mag_q << 1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_q      <= 1'b0;
            mag_q       <= '0;
            count_q     <= '0;
            result_q    <= 32'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            count_q     <= count_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule : fix22_to_fp32

// File: tb/tb_fix22_to_fp32.sv
// Directed self-checking bench for fix22_to_fp32: values, latency, backpressure and reset abort.
module tb_fix22_to_fp32;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fix22_to_fp32 dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, measure edges until out_valid, optionally consume it.
    task automatic convert(input string tag, input logic [21:0] word,
                           input logic [31:0] exp_res, input int exp_lat,
                           input logic consume);
        int n;
        check({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
        data_in  = word;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        data_in  = '0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        if (consume) begin
            step();
            check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_ready_post"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        data_in   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);

        convert("one",      22'h100000, 32'h3F800000, 2,  1'b1);
        convert("neg_two",  22'h200000, 32'hC0000000, 1,  1'b1);
        convert("lsb",      22'h000001, 32'h35800000, 22, 1'b1);
        convert("zero",     22'h000000, 32'h00000000, 1,  1'b1);
        convert("neg_half", 22'h380000, 32'hBF000000, 3,  1'b1);
        convert("max_pos",  22'h1FFFFF, 32'h3FFFFFF8, 2,  1'b1);
        convert("neg_lsb",  22'h3FFFFF, 32'hB5800000, 22, 1'b1);
        convert("three_q",  22'h0C0000, 32'h3F400000, 3,  1'b1);

        // Backpressure: result held, new words ignored while DONE.
        out_ready = 1'b0;
        convert("bp", 22'h100000, 32'h3F800000, 2, 1'b0);
        data_in  = 22'h0C0000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_result", result, 32'h3F800000);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_idle_stays", 32'(in_ready), 32'd1);
        check("bp_no_spurious", 32'(out_valid), 32'd0);

        // Reset in the middle of a long normalisation aborts it.
        data_in  = 22'h000001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        data_in  = '0;
        for (int i = 0; i < 5; i++) step();
        check("abort_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'h0);
        for (int i = 0; i < 25; i++) begin
            check("abort_no_pulse", 32'(out_valid), 32'd0);
            step();
        end
        convert("after_abort", 22'h080000, 32'h3F000000, 3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fix22_to_fp32
